// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB3 initiator: FSM state encoding
//               and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default widths of the address and data paths.
    localparam int c_ADDR_WIDTH = 8;
    localparam int c_DATA_WIDTH = 8;

    // Transfer FSM encoding. 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl_if
// Description : Bundles the command/response handshake of the fabric side and
//               the APB3 bus toward the slaves.
//   master modport : view of apb_master_ctrl (drives cmd_ready, rsp_*, APB
//                    control/address/data; receives commands and PREADY,
//                    PSLVERR, PRDATA)
//   slave modport  : opposite view (requester plus APB slave model)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // Response strobe
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    // APB3 bus
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );
endinterface : apb_master_ctrl_if
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_cnt
// Description : Counts consecutive PREADY-low ACCESS cycles. expired is high
//               during the TIMEOUT_CYCLES-th such cycle, so the transfer can
//               be aborted at that edge. TIMEOUT_CYCLES = 0 disables it.
//   PCLK, PRESETN : clock, asynchronous active-low reset
//   clear         : restart the count (new transfer accepted)
//   enable        : ACCESS cycle with PREADY low
//   expired       : wait budget used up in the current cycle
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic PCLK,
    input  wire logic PRESETN,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_cnt
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            // Count value seen during the last allowed ACCESS cycle.
            localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge PCLK or negedge PRESETN) begin
                if (!PRESETN) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable && !expired) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign expired = (r_cnt == c_LAST);
        end else begin : g_nocnt
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, PCLK, PRESETN, clear, enable};
            assign expired     = 1'b0;
        end
    endgenerate

endmodule : apb_timeout_cnt
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl
// Description : APB3 initiator. Turns single-beat read/write commands into
//               APB transfers (with wait states and optional timeout) and
//               returns read data / error on a one-cycle response strobe.
//   PCLK, PRESETN : clock, asynchronous active-low reset
//   bus.master    : command handshake, response strobe and APB3 bus
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_ADDR_WIDTH,
    parameter int DATA_WIDTH     = c_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic           PCLK,
    input  wire logic           PRESETN,
    apb_master_ctrl_if.master   bus
);

    apb_state_e            r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_accept;
    logic                  w_wait;
    logic                  w_expired;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;
    assign w_wait   = (r_state == ACCESS) && !bus.PREADY;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .clear   (w_accept),
        .enable  (w_wait),
        .expired (w_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            // Response fields are only non-zero during the strobe cycle.
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_paddr   <= bus.cmd_addr;
                        r_pwrite  <= bus.cmd_write;
                        r_pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err   <= bus.PSLVERR;
                        r_state     <= IDLE;
                    end else if (w_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end
                end

                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == IDLE);
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule : apb_master_ctrl
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_ctrl
// Description : Directed self-checking bench for apb_master_ctrl with
//               TIMEOUT_CYCLES = 4. Inputs change 1 time unit after the
//               rising edge; outputs are checked at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic PCLK;
    logic PRESETN;
    int   n_cmp;
    int   n_err;

    apb_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        PRESETN       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_psel",      {31'd0, bus.PSEL},      32'd0);
        chk("rst_penable",   {31'd0, bus.PENABLE},   32'd0);
        chk("rst_pwrite",    {31'd0, bus.PWRITE},    32'd0);
        chk("rst_paddr",     {24'd0, bus.PADDR},     32'd0);
        chk("rst_pwdata",    {24'd0, bus.PWDATA},    32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        PRESETN = 1'b1;
        tick();

        // ---------------- write, zero wait ----------------
        issue(1'b1, 8'h05, 8'hA5);
        tick();                                   // T0 accept -> SETUP
        bus.cmd_valid = 1'b0;
        chk("wr_setup_psel",    {31'd0, bus.PSEL},      32'd1);
        chk("wr_setup_penable", {31'd0, bus.PENABLE},   32'd0);
        chk("wr_setup_paddr",   {24'd0, bus.PADDR},     32'h05);
        chk("wr_setup_pwdata",  {24'd0, bus.PWDATA},    32'hA5);
        chk("wr_setup_pwrite",  {31'd0, bus.PWRITE},    32'd1);
        chk("wr_setup_ready",   {31'd0, bus.cmd_ready}, 32'd0);
        tick();                                   // T1 ACCESS
        chk("wr_acc_psel",      {31'd0, bus.PSEL},      32'd1);
        chk("wr_acc_penable",   {31'd0, bus.PENABLE},   32'd1);
        tick();                                   // T2 response
        chk("wr_rsp_valid",     {31'd0, bus.rsp_valid}, 32'd1);
        chk("wr_rsp_err",       {31'd0, bus.rsp_err},   32'd0);
        chk("wr_rsp_rdata",     {24'd0, bus.rsp_rdata}, 32'd0);
        chk("wr_rsp_psel",      {31'd0, bus.PSEL},      32'd0);
        chk("wr_rsp_ready",     {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        chk("wr_rsp_pulse",     {31'd0, bus.rsp_valid}, 32'd0);

        // ---------------- read, 2 wait states ----------------
        bus.PREADY = 1'b0;
        issue(1'b0, 8'h05, 8'h77);
        tick();                                   // SETUP
        bus.cmd_valid = 1'b0;
        chk("rd_setup_pwdata",  {24'd0, bus.PWDATA},    32'd0);
        chk("rd_setup_pwrite",  {31'd0, bus.PWRITE},    32'd0);
        for (int i = 0; i < 3; i++) begin         // ACCESS cycles 1..3
            tick();
            chk("rd_acc_penable", {31'd0, bus.PENABLE},   32'd1);
            chk("rd_acc_paddr",   {24'd0, bus.PADDR},     32'h05);
            chk("rd_acc_norsp",   {31'd0, bus.rsp_valid}, 32'd0);
        end
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'hA5;
        tick();                                   // T4 response
        bus.PRDATA = 8'h00;
        chk("rd_rsp_valid",     {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd_rsp_rdata",     {24'd0, bus.rsp_rdata}, 32'hA5);
        chk("rd_rsp_err",       {31'd0, bus.rsp_err},   32'd0);
        chk("rd_rsp_psel",      {31'd0, bus.PSEL},      32'd0);
        tick();

        // ---------------- slave error ----------------
        issue(1'b0, 8'h1F, 8'h00);
        tick();                                   // SETUP
        bus.cmd_valid = 1'b0;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 8'h3C;
        tick();                                   // ACCESS
        tick();                                   // response
        bus.PSLVERR = 1'b0;
        chk("se_rsp_valid",     {31'd0, bus.rsp_valid},   32'd1);
        chk("se_rsp_err",       {31'd0, bus.rsp_err},     32'd1);
        chk("se_rsp_timeout",   {31'd0, bus.rsp_timeout}, 32'd0);
        chk("se_rsp_rdata",     {24'd0, bus.rsp_rdata},   32'h3C);
        tick();

        // PSLVERR only during SETUP must be ignored
        issue(1'b0, 8'h1F, 8'h00);
        tick();                                   // SETUP
        bus.cmd_valid = 1'b0;
        bus.PSLVERR   = 1'b1;
        tick();                                   // ACCESS
        bus.PSLVERR   = 1'b0;
        tick();                                   // response
        chk("se2_rsp_valid",    {31'd0, bus.rsp_valid}, 32'd1);
        chk("se2_rsp_err",      {31'd0, bus.rsp_err},   32'd0);
        tick();

        // ---------------- timeout (4 cycles) ----------------
        bus.PREADY = 1'b0;
        issue(1'b1, 8'h10, 8'h11);
        tick();                                   // SETUP
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin         // ACCESS cycles 1..4
            tick();
            chk("to_acc_psel",    {31'd0, bus.PSEL},      32'd1);
            chk("to_acc_penable", {31'd0, bus.PENABLE},   32'd1);
            chk("to_acc_norsp",   {31'd0, bus.rsp_valid}, 32'd0);
        end
        tick();                                   // aborted
        chk("to_psel",          {31'd0, bus.PSEL},        32'd0);
        chk("to_rsp_valid",     {31'd0, bus.rsp_valid},   32'd1);
        chk("to_rsp_err",       {31'd0, bus.rsp_err},     32'd1);
        chk("to_rsp_timeout",   {31'd0, bus.rsp_timeout}, 32'd1);
        chk("to_rsp_rdata",     {24'd0, bus.rsp_rdata},   32'd0);
        tick();
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h66;
        issue(1'b0, 8'h20, 8'h00);
        tick(); bus.cmd_valid = 1'b0;
        tick(); tick();
        chk("to_next_valid",    {31'd0, bus.rsp_valid},   32'd1);
        chk("to_next_err",      {31'd0, bus.rsp_err},     32'd0);
        chk("to_next_timeout",  {31'd0, bus.rsp_timeout}, 32'd0);
        chk("to_next_rdata",    {24'd0, bus.rsp_rdata},   32'h66);
        bus.PRDATA = 8'h00;
        tick();

        // ---------------- back-to-back / held-off ----------------
        issue(1'b1, 8'h01, 8'h01);
        tick();                                   // first SETUP
        chk("bb1_paddr",        {24'd0, bus.PADDR},     32'h01);
        chk("bb1_pwdata",       {24'd0, bus.PWDATA},    32'h01);
        issue(1'b1, 8'h02, 8'h02);                // held high, next payload
        chk("bb1_ready_setup",  {31'd0, bus.cmd_ready}, 32'd0);
        tick();                                   // ACCESS
        chk("bb1_ready_acc",    {31'd0, bus.cmd_ready}, 32'd0);
        tick();                                   // first response
        chk("bb1_rsp_valid",    {31'd0, bus.rsp_valid}, 32'd1);
        chk("bb1_rsp_ready",    {31'd0, bus.cmd_ready}, 32'd1);
        chk("bb_gap_psel",      {31'd0, bus.PSEL},      32'd0);
        tick();                                   // second SETUP
        bus.cmd_valid = 1'b0;
        chk("bb2_psel",         {31'd0, bus.PSEL},      32'd1);
        chk("bb2_paddr",        {24'd0, bus.PADDR},     32'h02);
        chk("bb2_pwdata",       {24'd0, bus.PWDATA},    32'h02);
        chk("bb2_norsp",        {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        tick();
        chk("bb2_rsp_valid",    {31'd0, bus.rsp_valid}, 32'd1);
        tick();

        // ---------------- reset mid-ACCESS ----------------
        bus.PREADY = 1'b0;
        issue(1'b0, 8'h33, 8'h00);
        tick();                                   // SETUP
        bus.cmd_valid = 1'b0;
        tick();                                   // ACCESS
        chk("rm_acc_penable",   {31'd0, bus.PENABLE},   32'd1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("rm_async_psel",    {31'd0, bus.PSEL},      32'd0);
        chk("rm_async_penable", {31'd0, bus.PENABLE},   32'd0);
        tick();
        chk("rm_norsp",         {31'd0, bus.rsp_valid}, 32'd0);
        PRESETN    = 1'b1;
        bus.PREADY = 1'b1;
        tick();
        chk("rm_norsp2",        {31'd0, bus.rsp_valid}, 32'd0);
        chk("rm_ready",         {31'd0, bus.cmd_ready}, 32'd1);
        bus.PRDATA = 8'h5A;
        issue(1'b0, 8'h42, 8'h00);
        tick(); bus.cmd_valid = 1'b0;
        chk("rm_new_paddr",     {24'd0, bus.PADDR},     32'h42);
        tick(); tick();
        chk("rm_new_valid",     {31'd0, bus.rsp_valid}, 32'd1);
        chk("rm_new_rdata",     {24'd0, bus.rsp_rdata}, 32'h5A);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_apb_master_ctrl
`default_nettype wire

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB3 initiator for the FIC fabric subsystem. Converts single-beat read/write commands from fabric logic into APB transfers toward the fabric's APB slaves, including wait-stated register slaves. Returns read data, the slave error and a bus-timeout indication on a one-cycle response strobe.

## Interface
- ADDR_WIDTH, 8, width of PADDR and cmd_addr
- DATA_WIDTH, 8, width of PWDATA/PRDATA and command/response data
- TIMEOUT_CYCLES, 16, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  single clock, all logic on rising edge
- PRESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads; 0 on writes and timeouts
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1, decoded combinationally from state. On accept, register addr/write/wdata onto PADDR/PWRITE/PWDATA. PWDATA = 0 for reads. Go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, cmd_ready = 0. PREADY is ignored. Go to ACCESS unconditionally.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PREADY = 1: capture PRDATA (reads only), capture PSLVERR, go to IDLE, pulse rsp_valid next cycle.
  - PREADY = 0: stay in ACCESS and increment the wait counter.
- Timeout: if PREADY is still low in the TIMEOUT_CYCLES-th consecutive ACCESS cycle, go to IDLE at that edge. Next cycle rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- The wait counter clears on entry to SETUP. Counter width is clog2(TIMEOUT_CYCLES+1).
- PADDR/PWRITE/PWDATA hold stable from SETUP through end of ACCESS, and keep their last value in IDLE.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY = 1.
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; state IDLE, so cmd_ready = 1 out of reset.

## Timing
- Zero-wait transfer: accept edge at T0, SETUP in T0–T1, ACCESS in T1–T2, rsp_valid high in T2–T3.
- Each PREADY-low cycle adds one cycle of latency.
- cmd_ready is high in the same cycle as rsp_valid. A command accepted then starts SETUP the following cycle.
- Minimum command spacing is 3 cycles, with PSEL deasserted for at least one cycle between transfers.
- cmd_valid while busy: held off by cmd_ready = 0. The command is not lost as long as the requester holds it.
- rsp_valid has no backpressure. The consumer must take it in its one cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). No response is issued for the abandoned transfer.

## Structure
- Shared package apb_pkg holds:
  - state encodings: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10 (2'b11 recovers to IDLE);
  - default ADDR_WIDTH and DATA_WIDTH.
- One sub-module, apb_timeout_cnt. Inputs: clear, enable; parameter TIMEOUT_CYCLES; output expired. Tie expired to 0 when TIMEOUT_CYCLES = 0.

## Test plan
- Write, zero wait: cmd addr 0x05 data 0xA5 -> PSEL high 2 cycles, PENABLE high 1 cycle, PADDR = 0x05, PWDATA = 0xA5, PWRITE = 1; rsp_valid at T2, rsp_err = 0.
- Read with 2 wait states: cmd read 0x05, PREADY low for 2 ACCESS cycles, PRDATA = 0xA5 -> ACCESS lasts 3 cycles, rsp_rdata = 0xA5 at T4, address stable throughout.
- Slave error: read 0x1F, PREADY = 1 with PSLVERR = 1 -> rsp_err = 1, rsp_timeout = 0. PSLVERR pulsed during SETUP only -> rsp_err = 0.
- Timeout: TIMEOUT_CYCLES = 4, PREADY stuck low -> PSEL drops after 4 ACCESS cycles, rsp_valid with err = 1, timeout = 1, rdata = 0; next command completes normally.
- Back-to-back and held-off commands: cmd_valid held high for writes 0x01, 0x02 -> second accepted in the rsp_valid cycle, one idle cycle between PSELs, both responses in order.
- Reset mid-ACCESS: PRESETN low while PENABLE = 1 -> PSEL and PENABLE go to 0 asynchronously, no rsp_valid; after release, cmd_ready = 1 and a new read completes.
